exec_stage_mc: RTL and testbench

Parametrised execute stage for the 3-stage processor pipeline. It sits between decode/register-read and memory/write-back. It adds what the single-cycle execute stage lacks: an iterative signed divider with a busy stall, a persistent CMP flag register, and an internal return-address stack (RAS) for CALL/RET with overflow and underflow reporting. Opcodes are the `params_proc.v` constants: LW, LW_IMM, SW, ADD, SUB, MUL, DIV, AND, OR, NOT, CMP, JR, JPC, BRFL, CALL, RET, NOP.

---
 rtl/exec_stage_mc.sv | 192 +++++++++++++++++++
 tb/tb_exec_stage_mc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exec_stage_mc.sv
// exec_stage_mc: execute stage with an iterative signed divider, persistent CMP flags
// and a circular return-address stack for CALL/RET.
module exec_stage_mc #(
    parameter int DATA_WIDTH     = 16,
    parameter int PC_WIDTH       = 16,
    parameter int MEM_WIDTH      = 16,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 5,
    parameter int RAS_DEPTH      = 8
) (
    input  logic                      clk_in,
    input  logic                      RST,
    input  logic [CTRL_WIDTH-1:0]     ctrl_in,
    input  logic [PC_WIDTH-1:0]       pc_in,
    input  logic [REG_ADDR_WIDTH-1:0] A_addr,
    input  logic [REG_ADDR_WIDTH-1:0] B_addr,
    input  logic [DATA_WIDTH-1:0]     A,
    input  logic [DATA_WIDTH-1:0]     B,
    input  logic [DATA_WIDTH-1:0]     imm,
    output logic                      busy,
    output logic                      pc_chg,
    output logic [PC_WIDTH-1:0]       pc_out,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     data,
    output logic [MEM_WIDTH-1:0]      addr,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic [CTRL_WIDTH-1:0]     ctrl_out,
    output logic [1:0]                flags,
    output logic                      ras_ovf,
    output logic                      ras_unf
);
    localparam logic [CTRL_WIDTH-1:0] NOP = CTRL_WIDTH'(0), LW = CTRL_WIDTH'(1),
        LW_IMM = CTRL_WIDTH'(2), SW = CTRL_WIDTH'(3), ADD = CTRL_WIDTH'(4), SUB = CTRL_WIDTH'(5),
        MUL = CTRL_WIDTH'(6), DIV = CTRL_WIDTH'(7), AND = CTRL_WIDTH'(8), OR = CTRL_WIDTH'(9),
        NOT = CTRL_WIDTH'(10), CMP = CTRL_WIDTH'(11), JR = CTRL_WIDTH'(12), JPC = CTRL_WIDTH'(13),
        BRFL = CTRL_WIDTH'(14), CALL = CTRL_WIDTH'(15), RET = CTRL_WIDTH'(16);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int W  = DATA_WIDTH;

    logic                      busy_q, chg_q, we_q, ovf_q, unf_q, neg_q;
    logic [PC_WIDTH-1:0]       pco_q;
    logic [W-1:0]              data_q, rem_q, quo_q, den_q;
    logic [MEM_WIDTH-1:0]      addr_q;
    logic [REG_ADDR_WIDTH-1:0] ra_q, dst_q;
    logic [CTRL_WIDTH-1:0]     ctrl_q;
    logic [1:0]                flags_q;
    logic [CW-1:0]             step_q;
    logic [PC_WIDTH-1:0]       ras_q [RAS_DEPTH];
    logic [PW-1:0]             ptr_q;
    logic [PW:0]               rcnt_q;

    logic                      chg_d, we_d;
    logic [PC_WIDTH-1:0]       pco_d;
    logic [W-1:0]              data_d;
    logic [MEM_WIDTH-1:0]      addr_d;
    logic [REG_ADDR_WIDTH-1:0] ra_d;
    logic [CTRL_WIDTH-1:0]     ctrl_d;

    logic [W-1:0]        sum, abs_a, abs_b, rem_n, quo_n, res;
    logic [W:0]          rem_sh;
    logic                ge, last, ras_empty, ras_full, taken, unused_b;
    logic [PC_WIDTH-1:0] ras_top;

    assign unused_b  = ^B_addr;
    assign sum       = B + imm;
    assign abs_a     = A[W-1] ? -A : A;
    assign abs_b     = B[W-1] ? -B : B;
    assign ras_empty = rcnt_q == '0;
    assign ras_full  = rcnt_q == (PW+1)'(RAS_DEPTH);
    assign ras_top   = ras_q[ptr_q - 1'b1];
    assign taken     = |(flags_q & imm[1:0]);
    // Restoring step: shift the next dividend bit into the partial remainder.
    assign rem_sh    = {rem_q, quo_q[W-1]};
    assign ge        = rem_sh >= {1'b0, den_q};
    assign rem_n     = ge ? W'(rem_sh - {1'b0, den_q}) : rem_sh[W-1:0];
    assign quo_n     = {quo_q[W-2:0], ge};
    assign res       = neg_q ? -quo_n : quo_n;
    assign last      = step_q == CW'(W-1);

    always_comb begin
        data_d = '0;
        addr_d = '0;
        ra_d   = '0;
        we_d   = 1'b0;
        chg_d  = 1'b0;
        pco_d  = '0;
        ctrl_d = ctrl_in == DIV ? NOP : ctrl_in;
        case (ctrl_in)
            LW:     begin addr_d = MEM_WIDTH'(sum); ra_d = A_addr; end
            LW_IMM: begin data_d = imm; ra_d = A_addr; end
            SW:     begin we_d = 1'b1; addr_d = MEM_WIDTH'(sum); data_d = A; end
            ADD:    begin data_d = A + B; ra_d = A_addr; end
            SUB:    begin data_d = A - B; ra_d = A_addr; end
            MUL:    begin data_d = A * B; ra_d = A_addr; end
            AND:    begin data_d = A & B; ra_d = A_addr; end
            OR:     begin data_d = A | B; ra_d = A_addr; end
            NOT:    begin data_d = ~A; ra_d = A_addr; end
            JR:     begin chg_d = 1'b1; pco_d = PC_WIDTH'(A); end
            JPC:    begin chg_d = 1'b1; pco_d = pc_in + PC_WIDTH'(imm); end
            BRFL:   begin chg_d = taken; pco_d = taken ? PC_WIDTH'(A) : '0; end
            CALL:   begin chg_d = 1'b1; pco_d = PC_WIDTH'(A); end
            RET:    begin chg_d = 1'b1; pco_d = ras_empty ? '0 : ras_top; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            busy_q  <= 1'b0;
            chg_q   <= 1'b0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            neg_q   <= 1'b0;
            pco_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            ra_q    <= '0;
            dst_q   <= '0;
            ctrl_q  <= NOP;
            flags_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            step_q  <= '0;
            ptr_q   <= '0;
            rcnt_q  <= '0;
        end else if (busy_q) begin
            rem_q  <= rem_n;
            quo_q  <= quo_n;
            step_q <= step_q + 1'b1;
            if (last) begin
                busy_q <= 1'b0;
                data_q <= res;
                ra_q   <= dst_q;
                ctrl_q <= DIV;
            end
        end else begin
            chg_q  <= chg_d;
            we_q   <= we_d;
            pco_q  <= pco_d;
            data_q <= data_d;
            addr_q <= addr_d;
            ra_q   <= ra_d;
            ctrl_q <= ctrl_d;
            if (ctrl_in == CMP)
                flags_q <= {A == B, $signed(A) < $signed(B)};
            if (ctrl_in == DIV) begin
                busy_q <= 1'b1;
                rem_q  <= '0;
                quo_q  <= abs_a;
                den_q  <= abs_b;
                step_q <= '0;
                // Divide-by-zero must yield all ones, so never negate it.
                neg_q  <= (A[W-1] ^ B[W-1]) && (B != '0);
                dst_q  <= A_addr;
            end
            if (ctrl_in == CALL) begin
                ptr_q <= ptr_q + 1'b1;
                if (ras_full)
                    ovf_q <= 1'b1;
                else
                    rcnt_q <= rcnt_q + 1'b1;
            end
            if (ctrl_in == RET) begin
                if (ras_empty)
                    unf_q <= 1'b1;
                else begin
                    ptr_q  <= ptr_q - 1'b1;
                    rcnt_q <= rcnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in)
        if (!busy_q && ctrl_in == CALL)
            ras_q[ptr_q] <= pc_in + 1'b1;

    assign busy     = busy_q;
    assign pc_chg   = chg_q;
    assign pc_out   = pco_q;
    assign mem_we   = we_q;
    assign data     = data_q;
    assign addr     = addr_q;
    assign reg_addr = ra_q;
    assign ctrl_out = ctrl_q;
    assign flags    = flags_q;
    assign ras_ovf  = ovf_q;
    assign ras_unf  = unf_q;
endmodule

// File: tb/tb_exec_stage_mc.sv
// tb_exec_stage_mc: directed scoreboard bench for exec_stage_mc.
module tb_exec_stage_mc;
    localparam logic [4:0] NOP = 0, LW = 1, LW_IMM = 2, SW = 3, ADD = 4, SUB = 5, MUL = 6,
        DIV = 7, AND = 8, OR = 9, NOT = 10, CMP = 11, JR = 12, JPC = 13, BRFL = 14, CALL = 15, RET = 16;

    logic        clk_in = 1'b0, RST = 1'b0;
    logic [4:0]  ctrl_in = '0, A_addr = '0, B_addr = '0;
    logic [15:0] pc_in = '0, A = '0, B = '0, imm = '0;
    logic        busy, pc_chg, mem_we, ras_ovf, ras_unf;
    logic [15:0] pc_out, data, addr;
    logic [4:0]  reg_addr, ctrl_out;
    logic [1:0]  flags;

    always #5 clk_in = ~clk_in;

    exec_stage_mc dut (
        .clk_in(clk_in), .RST(RST), .ctrl_in(ctrl_in), .pc_in(pc_in), .A_addr(A_addr),
        .B_addr(B_addr), .A(A), .B(B), .imm(imm), .busy(busy), .pc_chg(pc_chg),
        .pc_out(pc_out), .mem_we(mem_we), .data(data), .addr(addr), .reg_addr(reg_addr),
        .ctrl_out(ctrl_out), .flags(flags), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    logic [79:0] obs;
    assign obs = {15'b0, busy, pc_chg, pc_out, mem_we, data, addr, reg_addr, ctrl_out, flags, ras_ovf, ras_unf};

    logic [79:0] q[$];
    int          n_run = 0, n_fail = 0;
    logic [1:0]  fl = '0;
    logic        ovf = 1'b0, unf = 1'b0;

    function automatic logic [79:0] ev(logic bsy, logic chg, logic [15:0] pco, logic we,
                                       logic [15:0] d, logic [15:0] a, logic [4:0] ra, logic [4:0] ct);
        return {15'b0, bsy, chg, pco, we, d, a, ra, ct, fl, ovf, unf};
    endfunction

    task automatic chk(input string tag, input logic [79:0] e);
        n_run++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic collect(input string tag);
        if (q.size() == 0) begin
            n_run++;
            n_fail++;
            $error("FAIL %s: observed no pending entry expected one", tag);
        end else
            chk(tag, q.pop_front());
    endtask

    task automatic op(input logic [4:0] c, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] im, input logic [15:0] pc, input logic [4:0] ra);
        ctrl_in = c;
        A = a;
        B = b;
        imm = im;
        pc_in = pc;
        A_addr = ra;
        B_addr = ra + 5'd1;
    endtask

    task automatic step(input string tag, input logic [79:0] e);
        q.push_back(e);
        @(posedge clk_in);
        #1;
        collect(tag);
    endtask

    task automatic div(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] quo);
        op(DIV, a, b, 16'd0, 16'd0, 5'd9);
        q.push_back(ev(0, 0, 0, 0, quo, 0, 9, DIV));
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_in);
            #1;
            chk({tag, "_busy"}, ev(1, 0, 0, 0, 0, 0, 0, NOP));
            if (i == 2) op(ADD, 16'h1111, 16'h2222, 16'd0, 16'd0, 5'd3);
        end
        @(posedge clk_in);
        #1;
        collect(tag);
    endtask

    initial begin
        #3;
        chk("reset", ev(0, 0, 0, 0, 0, 0, 0, NOP));
        @(posedge clk_in);
        #1;
        RST = 1'b1;

        op(ADD, 16'd50, 16'd85, 16'd0, 16'd0, 5'd10);
        step("add", ev(0, 0, 0, 0, 16'd135, 0, 10, ADD));
        op(SW, 16'd5, 16'd65, 16'd45, 16'd0, 5'd2);
        step("sw", ev(0, 0, 0, 1, 16'd5, 16'd110, 0, SW));
        op(LW, 16'd7, 16'd100, -16'sd4, 16'd0, 5'd3);
        step("lw", ev(0, 0, 0, 0, 0, 16'd96, 3, LW));
        op(LW_IMM, 16'd7, 16'd0, 16'h1234, 16'd0, 5'd7);
        step("lw_imm", ev(0, 0, 0, 0, 16'h1234, 0, 7, LW_IMM));
        op(SUB, 16'd10, 16'd20, 16'd0, 16'd0, 5'd4);
        step("sub", ev(0, 0, 0, 0, 16'hFFF6, 0, 4, SUB));
        op(MUL, -16'sd3, 16'd7, 16'd0, 16'd0, 5'd5);
        step("mul_neg", ev(0, 0, 0, 0, -16'sd21, 0, 5, MUL));
        op(MUL, 16'd300, 16'd300, 16'd0, 16'd0, 5'd5);
        step("mul_wrap", ev(0, 0, 0, 0, 16'h5F90, 0, 5, MUL));
        op(AND, 16'hF0F0, 16'h3C3C, 16'd0, 16'd0, 5'd6);
        step("and", ev(0, 0, 0, 0, 16'h3030, 0, 6, AND));
        op(OR, 16'hF0F0, 16'h3C3C, 16'd0, 16'd0, 5'd6);
        step("or", ev(0, 0, 0, 0, 16'hFCFC, 0, 6, OR));
        op(NOT, 16'h00FF, 16'd0, 16'd0, 16'd0, 5'd8);
        step("not", ev(0, 0, 0, 0, 16'hFF00, 0, 8, NOT));
        op(JR, 16'h4000, 16'd0, 16'd0, 16'd0, 5'd1);
        step("jr", ev(0, 1, 16'h4000, 0, 0, 0, 0, JR));
        op(JPC, 16'd0, 16'd0, 16'h0020, 16'hFFF0, 5'd1);
        step("jpc_wrap", ev(0, 1, 16'h0010, 0, 0, 0, 0, JPC));
        op(5'd31, 16'd9, 16'd9, 16'd9, 16'd9, 5'd9);
        step("undef", ev(0, 0, 0, 0, 0, 0, 0, 5'd31));

        div("div_50_m2", 16'd50, -16'sd2, -16'sd25);
        div("div_b0", 16'd7, 16'd0, 16'hFFFF);
        div("div_neg_b0", -16'sd7, 16'd0, 16'hFFFF);
        div("div_min_m1", 16'h8000, 16'hFFFF, 16'h8000);
        div("div_m100_7", -16'sd100, 16'd7, -16'sd14);

        op(CMP, -16'sd5, 16'd80, 16'd0, 16'd0, 5'd3);
        fl = 2'b01;
        step("cmp_lt", ev(0, 0, 0, 0, 0, 0, 0, CMP));
        op(BRFL, 16'd5000, 16'd0, 16'd1, 16'd0, 5'd3);
        step("brfl_lt", ev(0, 1, 16'd5000, 0, 0, 0, 0, BRFL));
        op(CMP, 16'd3, 16'd3, 16'd0, 16'd0, 5'd3);
        fl = 2'b10;
        step("cmp_eq", ev(0, 0, 0, 0, 0, 0, 0, CMP));
        op(BRFL, 16'd5000, 16'd0, 16'd1, 16'd0, 5'd3);
        step("brfl_nt", ev(0, 0, 0, 0, 0, 0, 0, BRFL));
        op(BRFL, 16'd6000, 16'd0, 16'd2, 16'd0, 5'd3);
        step("brfl_eq", ev(0, 1, 16'd6000, 0, 0, 0, 0, BRFL));

        for (int i = 0; i < 9; i++) begin
            op(CALL, 16'(200 + i), 16'd0, 16'd0, 16'(100 + i), 5'd0);
            if (i == 8) ovf = 1'b1;
            step("call_n", ev(0, 1, 16'(200 + i), 0, 0, 0, 0, CALL));
        end
        for (int i = 8; i >= 1; i--) begin
            op(RET, 16'd0, 16'd0, 16'd0, 16'd0, 5'd0);
            step("ret_n", ev(0, 1, 16'(101 + i), 0, 0, 0, 0, RET));
        end
        op(RET, 16'd0, 16'd0, 16'd0, 16'd0, 5'd0);
        unf = 1'b1;
        step("ret_unf", ev(0, 1, 0, 0, 0, 0, 0, RET));

        op(CALL, 16'd48000, 16'd0, 16'd0, 16'd17541, 5'd0);
        step("call", ev(0, 1, 16'd48000, 0, 0, 0, 0, CALL));
        op(RET, 16'd0, 16'd0, 16'd0, 16'd0, 5'd0);
        step("ret", ev(0, 1, 16'd17542, 0, 0, 0, 0, RET));
        op(RET, 16'd0, 16'd0, 16'd0, 16'd0, 5'd0);
        step("ret_empty", ev(0, 1, 0, 0, 0, 0, 0, RET));

        op(DIV, 16'd1000, 16'd3, 16'd0, 16'd0, 5'd9);
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #2;
        RST = 1'b0;
        #1;
        fl = '0;
        ovf = 1'b0;
        unf = 1'b0;
        chk("rst_div", ev(0, 0, 0, 0, 0, 0, 0, NOP));
        #1;
        RST = 1'b1;
        op(RET, 16'd0, 16'd0, 16'd0, 16'd0, 5'd0);
        unf = 1'b1;
        step("ret_after_rst", ev(0, 1, 0, 0, 0, 0, 0, RET));

        op(CALL, 16'd300, 16'd0, 16'd0, 16'd40, 5'd0);
        step("call_a", ev(0, 1, 16'd300, 0, 0, 0, 0, CALL));
        op(CALL, 16'd301, 16'd0, 16'd0, 16'd41, 5'd0);
        step("call_b", ev(0, 1, 16'd301, 0, 0, 0, 0, CALL));
        #2;
        RST = 1'b0;
        #1;
        unf = 1'b0;
        chk("rst_call", ev(0, 0, 0, 0, 0, 0, 0, NOP));
        #1;
        RST = 1'b1;
        op(RET, 16'd0, 16'd0, 16'd0, 16'd0, 5'd0);
        unf = 1'b1;
        step("ret_rst_call", ev(0, 1, 0, 0, 0, 0, 0, RET));
        op(CALL, 16'd500, 16'd0, 16'd0, 16'd77, 5'd0);
        step("call_c", ev(0, 1, 16'd500, 0, 0, 0, 0, CALL));
        op(RET, 16'd0, 16'd0, 16'd0, 16'd0, 5'd0);
        step("ret_c", ev(0, 1, 16'd78, 0, 0, 0, 0, RET));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
